// File: rtl/caf_pkg.sv
// rtl/caf_pkg.sv - shared state encoding and slice offset helper for the CAF sweep controller
package caf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONFIG  = 3'd1,
      ST_STREAM  = 3'd2,
      ST_COLLECT = 3'd3,
      ST_REPORT  = 3'd4
   } caf_state_e;

   typedef struct packed {
      logic        neg;
      logic [30:0] mag;
   } caf_offset_t;

   // Slice k sits at signed offset k - foas/2, so the sweep is centred on zero.
   function automatic caf_offset_t caf_offset(input int k, input int foas);
      caf_offset_t o;
      int          s;
      s     = k - (foas / 2);
      o.neg = (s < 0);
      o.mag = 31'(o.neg ? -s : s);
      return o;
   endfunction

endpackage

// File: rtl/caf_sweep_ctrl_if.sv
// rtl/caf_sweep_ctrl_if.sv - host, configuration, sample, result and report signals of the sweep controller
interface caf_sweep_ctrl_if #(
   parameter int phase_bits          = 10,
   parameter int foas_counter_bits   = 3,
   parameter int length_counter_bits = 3,
   parameter int out_max_bits        = 64
);

   logic                           start;
   logic [phase_bits-1:0]          spacing;
   logic                           busy;

   logic                           cfg_valid;
   logic                           cfg_ready;
   logic [phase_bits-1:0]          cfg_step;
   logic                           cfg_neg;
   logic [foas_counter_bits-1:0]   cfg_index;

   logic                           smp_en;
   logic                           smp_valid;
   logic                           smp_ready;

   logic                           res_valid;
   logic                           res_ready;
   logic [out_max_bits-1:0]        res_max;
   logic [length_counter_bits-1:0] res_lag;

   logic [out_max_bits-1:0]        best_max;
   logic [length_counter_bits-1:0] best_lag;
   logic [foas_counter_bits-1:0]   best_foa;
   logic                           done_valid;
   logic                           done_ready;

   modport master (
      output start, spacing, cfg_ready, smp_valid, smp_ready,
             res_valid, res_max, res_lag, done_ready,
      input  busy, cfg_valid, cfg_step, cfg_neg, cfg_index, smp_en,
             res_ready, best_max, best_lag, best_foa, done_valid
   );

   modport slave (
      input  start, spacing, cfg_ready, smp_valid, smp_ready,
             res_valid, res_max, res_lag, done_ready,
      output busy, cfg_valid, cfg_step, cfg_neg, cfg_index, smp_en,
             res_ready, best_max, best_lag, best_foa, done_valid
   );

endinterface

// File: rtl/caf_peak_tracker.sv
// rtl/caf_peak_tracker.sv - running global peak over per-slice results of one sweep
module caf_peak_tracker #(
   parameter int foas                = 3,
   parameter int foas_counter_bits   = 3,
   parameter int length_counter_bits = 3,
   parameter int out_max_bits        = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear_i,
   input  logic                           accept_i,
   input  logic [out_max_bits-1:0]        res_max_i,
   input  logic [length_counter_bits-1:0] res_lag_i,
   output logic [out_max_bits-1:0]        best_max_o,
   output logic [length_counter_bits-1:0] best_lag_o,
   output logic [foas_counter_bits-1:0]   best_foa_o,
   output logic                           last_o
);

   localparam logic [foas_counter_bits-1:0] LastIndex = foas_counter_bits'(foas - 1);

   logic [foas_counter_bits-1:0]   count_q;
   logic [out_max_bits-1:0]        best_max_q;
   logic [length_counter_bits-1:0] best_lag_q;
   logic [foas_counter_bits-1:0]   best_foa_q;

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         count_q    <= '0;
         best_max_q <= '0;
         best_lag_q <= '0;
         best_foa_q <= '0;
      end else if (accept_i) begin
         // Strict compare keeps the earlier slice on ties; the first result always loads.
         if ((count_q == '0) || (res_max_i > best_max_q)) begin
            best_max_q <= res_max_i;
            best_lag_q <= res_lag_i;
            best_foa_q <= count_q;
         end
         count_q <= count_q + foas_counter_bits'(1);
      end
   end

   assign best_max_o = best_max_q;
   assign best_lag_o = best_lag_q;
   assign best_foa_o = best_foa_q;
   assign last_o     = (count_q == LastIndex);

endmodule

// File: rtl/caf_sweep_ctrl.sv
// rtl/caf_sweep_ctrl.sv - runs one cross-ambiguity sweep: slice config, sample gating, peak collection, report
module caf_sweep_ctrl
   import caf_pkg::*;
#(
   parameter int phase_bits          = 10,
   parameter int foas                = 3,
   parameter int foas_counter_bits   = 3,
   parameter int length              = 5,
   parameter int length_counter_bits = 3,
   parameter int out_max_bits        = 64
) (
   input logic             clk,
   input logic             reset,
   caf_sweep_ctrl_if.slave bus
);

   localparam logic [foas_counter_bits-1:0]   LastIndex = foas_counter_bits'(foas - 1);
   localparam logic [length_counter_bits-1:0] BeatTotal = length_counter_bits'(length);

   caf_state_e                     state_q;
   logic [phase_bits-1:0]          spacing_q;
   logic [length_counter_bits-1:0] beat_cnt_q;
   logic [foas_counter_bits-1:0]   cfg_index_q;
   logic [phase_bits-1:0]          cfg_step_q;
   logic                           cfg_neg_q;
   logic                           cfg_valid_q;
   logic                           busy_q;
   logic                           smp_en_q;
   logic                           res_ready_q;
   logic                           done_valid_q;

   logic [foas_counter_bits-1:0]   cfg_index_d;
   caf_offset_t                    off_start_d;
   caf_offset_t                    off_next_d;
   logic [phase_bits-1:0]          step_start_d;
   logic [phase_bits-1:0]          step_next_d;
   logic                           start_acc;
   logic                           res_acc;
   logic                           last_res;

   // Step products wrap modulo 2^phase_bits, matching the engine's phase accumulator.
   assign cfg_index_d  = cfg_index_q + foas_counter_bits'(1);
   assign off_start_d  = caf_offset(0, foas);
   assign off_next_d   = caf_offset(int'(cfg_index_d), foas);
   assign step_start_d = phase_bits'(off_start_d.mag * 31'(bus.spacing));
   assign step_next_d  = phase_bits'(off_next_d.mag * 31'(spacing_q));

   assign start_acc = (state_q == ST_IDLE) && bus.start;
   assign res_acc   = res_ready_q && bus.res_valid;

   caf_peak_tracker #(
      .foas                (foas),
      .foas_counter_bits   (foas_counter_bits),
      .length_counter_bits (length_counter_bits),
      .out_max_bits        (out_max_bits)
   ) u_peak (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (start_acc),
      .accept_i   (res_acc),
      .res_max_i  (bus.res_max),
      .res_lag_i  (bus.res_lag),
      .best_max_o (bus.best_max),
      .best_lag_o (bus.best_lag),
      .best_foa_o (bus.best_foa),
      .last_o     (last_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         spacing_q    <= '0;
         beat_cnt_q   <= '0;
         cfg_index_q  <= '0;
         cfg_step_q   <= '0;
         cfg_neg_q    <= 1'b0;
         cfg_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         smp_en_q     <= 1'b0;
         res_ready_q  <= 1'b0;
         done_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  spacing_q   <= bus.spacing;
                  beat_cnt_q  <= '0;
                  busy_q      <= 1'b1;
                  cfg_valid_q <= 1'b1;
                  cfg_index_q <= '0;
                  cfg_step_q  <= step_start_d;
                  cfg_neg_q   <= off_start_d.neg;
                  state_q     <= ST_CONFIG;
               end
            end
            ST_CONFIG: begin
               if (cfg_valid_q && bus.cfg_ready) begin
                  if (cfg_index_q == LastIndex) begin
                     cfg_valid_q <= 1'b0;
                     smp_en_q    <= 1'b1;
                     state_q     <= ST_STREAM;
                  end else begin
                     cfg_index_q <= cfg_index_d;
                     cfg_step_q  <= step_next_d;
                     cfg_neg_q   <= off_next_d.neg;
                  end
               end
            end
            ST_STREAM: begin
               // The counter saturates at length, so a beat slipping through the last enabled cycle is not counted.
               if (beat_cnt_q == BeatTotal) begin
                  smp_en_q    <= 1'b0;
                  res_ready_q <= 1'b1;
                  state_q     <= ST_COLLECT;
               end else if (bus.smp_valid && bus.smp_ready) begin
                  beat_cnt_q <= beat_cnt_q + length_counter_bits'(1);
               end
            end
            ST_COLLECT: begin
               if (res_acc && last_res) begin
                  res_ready_q  <= 1'b0;
                  done_valid_q <= 1'b1;
                  state_q      <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (bus.done_ready) begin
                  done_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.cfg_valid  = cfg_valid_q;
   assign bus.cfg_step   = cfg_step_q;
   assign bus.cfg_neg    = cfg_neg_q;
   assign bus.cfg_index  = cfg_index_q;
   assign bus.smp_en     = smp_en_q;
   assign bus.res_ready  = res_ready_q;
   assign bus.done_valid = done_valid_q;

endmodule
